// File: rtl/adc_pkg.sv
// adc_pkg: shared FSM states, segment codes and default widths for the ADC display path
package adc_pkg;
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, SCALE, BCD, UPDATE} rd_state_e;
  localparam int DATA_W_D = 8;
  localparam int PTR_W_D = 8;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [9:0][6:0] SEG_LUT = {7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: one BCD digit to active-low {g..a} segments, with blanking
module seg7_decode
  import adc_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);
  // non-decimal codes are shown blank rather than as garbage
  always_comb seg = (blank || bcd > 4'd9) ? SEG_BLANK : SEG_LUT[bcd];
endmodule

// File: rtl/temp_display_reader.sv
// temp_display_reader: drains ADC codes from the ring buffer, scales to degC and drives three 7-seg digits
module temp_display_reader
  import adc_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int PTR_W = PTR_W_D,
  parameter int SCALE_NUM = 500,
  parameter int SCALE_SHIFT = 8,
  parameter int OFFSET = 0,
  parameter int TEMP_W = 10
) (
  input  logic              clk_adc,
  input  logic              rst,
  input  logic [PTR_W-1:0]  head,
  output logic [PTR_W-1:0]  tail,
  output logic              fifo_rd_en,
  output logic [PTR_W-1:0]  fifo_rd_addr,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic [11:0]       temp_bcd,
  output logic              temp_valid,
  output logic [6:0]        hex2,
  output logic [6:0]        hex1,
  output logic [6:0]        hex0
);
  localparam int PROD_W = DATA_W + 10;
  localparam int DD_W = 12 + TEMP_W;
  localparam int CNT_W = $clog2(TEMP_W);
  rd_state_e state;
  logic [DATA_W-1:0] code_r;
  logic [TEMP_W-1:0] bin_r, bin_next, t_scaled;
  logic [11:0] bcd_r, bcd_adj, bcd_next;
  logic [CNT_W-1:0] cnt;
  logic [PROD_W-1:0] prod, shifted, sat;
  logic [DD_W-1:0] dd_next;
  logic [6:0] seg2, seg1, seg0;
  logic avail;
  assign fifo_rd_addr = tail + 1'b1;
  assign avail = fifo_rd_addr != head;
  // full-width scale, offset with saturation at zero, clamp to the three-digit display range
  always_comb begin
    prod = PROD_W'(code_r) * PROD_W'(SCALE_NUM);
    shifted = prod >> SCALE_SHIFT;
    sat = shifted < PROD_W'(OFFSET) ? '0 : shifted - PROD_W'(OFFSET);
    t_scaled = sat > PROD_W'(999) ? TEMP_W'(999) : TEMP_W'(sat);
  end
  // one double-dabble step: add 3 to any digit >= 5, then shift the next binary bit in
  always_comb begin
    bcd_adj[3:0] = bcd_r[3:0] >= 4'd5 ? bcd_r[3:0] + 4'd3 : bcd_r[3:0];
    bcd_adj[7:4] = bcd_r[7:4] >= 4'd5 ? bcd_r[7:4] + 4'd3 : bcd_r[7:4];
    bcd_adj[11:8] = bcd_r[11:8] >= 4'd5 ? bcd_r[11:8] + 4'd3 : bcd_r[11:8];
    dd_next = {bcd_adj, bin_r} << 1;
    bcd_next = dd_next[DD_W-1 -: 12];
    bin_next = dd_next[TEMP_W-1:0];
  end
  seg7_decode u_seg2 (.bcd(bcd_r[11:8]), .blank(bcd_r[11:8] == 4'd0), .seg(seg2));
  seg7_decode u_seg1 (.bcd(bcd_r[7:4]), .blank(bcd_r[11:4] == 8'd0), .seg(seg1));
  seg7_decode u_seg0 (.bcd(bcd_r[3:0]), .blank(1'b0), .seg(seg0));
  // reader FSM: read, capture and advance tail, scale, convert, then publish to the display
  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tail <= '1;
      fifo_rd_en <= 1'b0;
      code_r <= '0;
      bin_r <= '0;
      bcd_r <= '0;
      cnt <= '0;
      temp_bcd <= '0;
      temp_valid <= 1'b0;
      hex2 <= SEG_BLANK;
      hex1 <= SEG_BLANK;
      hex0 <= SEG_BLANK;
    end else begin
      case (state)
        IDLE: begin
          state <= avail ? READ : IDLE;
          fifo_rd_en <= avail;
        end
        READ: begin
          fifo_rd_en <= 1'b0;
          state <= CAPTURE;
        end
        CAPTURE: begin
          code_r <= fifo_rd_data;
          tail <= fifo_rd_addr;
          state <= SCALE;
        end
        SCALE: begin
          bin_r <= t_scaled;
          bcd_r <= '0;
          cnt <= '0;
          state <= BCD;
        end
        BCD: begin
          bcd_r <= bcd_next;
          bin_r <= bin_next;
          cnt <= cnt + 1'b1;
          state <= cnt == CNT_W'(TEMP_W - 1) ? UPDATE : BCD;
        end
        UPDATE: begin
          temp_bcd <= bcd_r;
          hex2 <= seg2;
          hex1 <= seg1;
          hex0 <= seg0;
          temp_valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
